dma_write_engine: RTL and testbench

- Consumes the 32-bit word stream produced by `packet_parser` (its `data_out`/`valid_out`/`ready_out` side).
- Writes each word to consecutive memory addresses named by a single-entry descriptor (base address, length in words).
- Signals completion with a one-cycle pulse.
- It is the DMA stage directly downstream of the parser and the terminal block of the packet path.

---
 rtl/dma_pkg.sv | 19 +
 rtl/dma_write_engine.sv | 103 ++++++++++
 tb/tb_dma_write_engine.sv | 319 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dma_pkg.sv
// Shared definitions for the DMA write engine: FSM state encoding and word sizing.
package dma_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    WRITE = 2'd2,
    DONE  = 2'd3
  } dma_state_t;

  localparam int DEFAULT_WIDTH = 32;
  localparam int WORD_BYTES    = DEFAULT_WIDTH / 8;

  // Bytes per memory word for an arbitrary data width.
  function automatic int word_bytes(input int width);
    return width / 8;
  endfunction

endpackage

// File: rtl/dma_write_engine.sv
// Single-descriptor DMA write engine: drains the parser word stream into
// consecutive memory words starting at a base byte address.
module dma_write_engine
  import dma_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int LEN_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              desc_valid,
  output logic              desc_ready,
  input  logic [ADDR_W-1:0] desc_addr,
  input  logic [LEN_W-1:0]  desc_len,
  input  logic [WIDTH-1:0]  s_data,
  input  logic              s_valid,
  output logic              s_ready,
  output logic              mem_wr_en,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic              mem_ack,
  output logic              busy,
  output logic              done,
  output logic              err_align,
  output logic [LEN_W-1:0]  words_done,
  output logic [1:0]        fsm_state
);

  localparam int                WB         = word_bytes(WIDTH);
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ADDR_W'(WB - 1);
  localparam logic [ADDR_W-1:0] ADDR_STEP  = ADDR_W'(WB);

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; ready never depends on valid, and mem_addr/mem_wdata hold until
  // the edge where mem_wr_en and mem_ack are both high.
  dma_state_t        state;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  remaining;
  logic [WIDTH-1:0]  wdata;
  logic              misaligned;

  assign misaligned = (desc_addr & ALIGN_MASK) != '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      addr       <= '0;
      remaining  <= '0;
      wdata      <= '0;
      words_done <= '0;
      err_align  <= 1'b0;
    end else begin
      err_align <= 1'b0;
      case (state)
        IDLE: begin
          if (desc_valid) begin
            if (misaligned) begin
              err_align <= 1'b1;
            end else if (desc_len == '0) begin
              state <= DONE;
            end else begin
              addr       <= desc_addr;
              remaining  <= desc_len;
              words_done <= '0;
              state      <= FETCH;
            end
          end
        end
        FETCH: begin
          if (s_valid) begin
            wdata <= s_data;
            state <= WRITE;
          end
        end
        WRITE: begin
          if (mem_ack) begin
            addr       <= addr + ADDR_STEP;
            remaining  <= remaining - 1'b1;
            words_done <= words_done + 1'b1;
            state      <= (remaining == LEN_W'(1)) ? DONE : FETCH;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign desc_ready = (state == IDLE);
  assign s_ready    = (state == FETCH);
  assign mem_wr_en  = (state == WRITE);
  assign mem_addr   = addr;
  assign mem_wdata  = wdata;
  assign busy       = (state != IDLE);
  assign done       = (state == DONE);
  assign fsm_state  = state;

endmodule

// File: tb/tb_dma_write_engine.sv
// Bench for dma_write_engine: drives descriptors and a stream, predicts the
// write sequence from base/length arithmetic and compares what memory sees.
module tb_dma_write_engine;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        desc_valid = 1'b0;
  logic        desc_ready;
  logic [31:0] desc_addr = '0;
  logic [15:0] desc_len = '0;
  logic [31:0] s_data = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic        mem_wr_en;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ack = 1'b0;
  logic        busy;
  logic        done;
  logic        err_align;
  logic [15:0] words_done;
  logic [1:0]  fsm_state;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] src_q[$];
  logic [31:0] exp_q[$];
  logic [31:0] exp_addr_q[$];
  logic [31:0] obs_addr_q[$];
  logic [31:0] obs_data_q[$];
  int          done_cnt;
  int          done_k;
  int          viol;
  logic        ready_at_issue;

  dma_write_engine #(.WIDTH(32), .ADDR_W(32), .LEN_W(16)) dut (
    .clk(clk), .rst(rst),
    .desc_valid(desc_valid), .desc_ready(desc_ready),
    .desc_addr(desc_addr), .desc_len(desc_len),
    .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
    .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .busy(busy), .done(done), .err_align(err_align),
    .words_done(words_done), .fsm_state(fsm_state)
  );

  always #5 clk = ~clk;

  // Reference model: word i of a transfer lands at base + 4*i (mod 2^32).
  task automatic build_expected(input logic [31:0] base, input int len);
    exp_q.delete();
    exp_addr_q.delete();
    for (int i = 0; i < len; i++) begin
      exp_addr_q.push_back(base + 32'(4 * i));
      exp_q.push_back(src_q[i]);
    end
  endtask

  task automatic fill_src(input int len);
    src_q.delete();
    for (int i = 0; i < len; i++) src_q.push_back($urandom);
  endtask

  // Issues one descriptor, then streams src_q and answers writes until done
  // (or until abort_after writes have completed).
  task automatic run_transfer(input logic [31:0] base, input logic [15:0] len,
                              input int ack_wait, input bit rand_mode,
                              input int abort_after, output bit timeout);
    int wait_cnt, cur_wait, src_idx, post;
    bit seen_done, held, took, finished;
    logic wr_s, rdy_s;
    logic [31:0] h_addr, h_data;
    obs_addr_q.delete();
    obs_data_q.delete();
    done_cnt = 0; done_k = -1; viol = 0; timeout = 0;
    wait_cnt = 0; src_idx = 0; post = 0;
    seen_done = 0; held = 0; took = 0; finished = 0;
    h_addr = '0; h_data = '0;
    cur_wait = rand_mode ? int'($urandom_range(0, 3)) : ack_wait;
    @(negedge clk);
    desc_valid = 1'b1; desc_addr = base; desc_len = len;
    ready_at_issue = desc_ready;
    @(posedge clk);
    for (int k = 1; k <= 4000; k++) begin
      @(negedge clk);
      desc_valid = 1'b0;
      desc_addr  = $urandom;
      desc_len   = 16'($urandom);
      if (took) begin s_valid = 1'b0; took = 0; end
      if (done) begin
        done_cnt++;
        if (!seen_done) done_k = k;
        seen_done = 1;
      end
      if (seen_done) begin
        post++;
        if (post > 3) begin finished = 1; break; end
      end
      if (abort_after > 0 && obs_addr_q.size() >= abort_after) begin
        finished = 1; break;
      end
      wr_s = mem_wr_en;
      rdy_s = s_ready;
      if (wr_s) begin
        if (rdy_s) viol++;
        if (held && (mem_addr !== h_addr || mem_wdata !== h_data)) viol++;
        h_addr = mem_addr;
        h_data = mem_wdata;
      end
      if (!s_valid && src_idx < src_q.size() && (!rand_mode || $urandom_range(0, 1) == 1)) begin
        s_valid = 1'b1;
        s_data  = src_q[src_idx];
      end
      if (!rand_mode && ack_wait == 0) mem_ack = 1'b1;
      else if (wr_s) mem_ack = (wait_cnt >= cur_wait);
      else mem_ack = rand_mode ? 1'($urandom_range(0, 1)) : 1'b0;
      @(posedge clk);
      if (s_valid && rdy_s) begin src_idx++; took = 1; end
      if (wr_s && mem_ack) begin
        obs_addr_q.push_back(h_addr);
        obs_data_q.push_back(h_data);
        wait_cnt = 0; held = 0;
        cur_wait = rand_mode ? int'($urandom_range(0, 3)) : ack_wait;
      end else if (wr_s) begin
        wait_cnt++; held = 1;
      end
    end
    if (!finished) timeout = 1;
    @(negedge clk);
    s_valid = 1'b0;
    mem_ack = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    if ({desc_ready, s_ready, mem_wr_en, busy, done, err_align} !== 6'b100000) begin
      n_fail++; $display("FAIL reset_flags: got %b expected 100000", {desc_ready, s_ready, mem_wr_en, busy, done, err_align});
    end
    n_checks++;
    if ({mem_addr, mem_wdata, words_done} !== 80'h0) begin
      n_fail++; $display("FAIL reset_values: addr %h data %h words %0d expected zeros", mem_addr, mem_wdata, words_done);
    end
    n_checks++;
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic(input int ack_wait, input string tag);
    bit to;
    fill_src(24);
    for (int i = 0; i < 24; i++) begin
      case (i / 6)
        0: src_q[i][31:24] = 8'hA1;
        1: src_q[i][31:24] = 8'hB2;
        2: src_q[i][31:24] = 8'hC3;
        default: src_q[i][31:24] = 8'hD4;
      endcase
    end
    src_q[23] = 32'hD4F40099;
    build_expected(32'h1000, 24);
    run_transfer(32'h1000, 16'd24, ack_wait, 1'b0, 0, to);
    if (to !== 1'b0) begin n_fail++; $display("FAIL %s_timeout: transfer never finished", tag); end
    n_checks++;
    if (ready_at_issue !== 1'b1) begin n_fail++; $display("FAIL %s_desc_ready: got %b expected 1", tag, ready_at_issue); end
    n_checks++;
    if (obs_addr_q.size() !== 24) begin n_fail++; $display("FAIL %s_count: got %0d writes expected 24", tag, obs_addr_q.size()); end
    n_checks++;
    for (int i = 0; i < 24 && i < obs_addr_q.size(); i++) begin
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL %s_write%0d: got %h/%h expected %h/%h", tag, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
      end
      n_checks++;
    end
    if (done_cnt !== 1) begin n_fail++; $display("FAIL %s_done_pulses: got %0d expected 1", tag, done_cnt); end
    n_checks++;
    if (words_done !== 16'd24) begin n_fail++; $display("FAIL %s_words_done: got %0d expected 24", tag, words_done); end
    n_checks++;
    if (viol !== 0) begin n_fail++; $display("FAIL %s_hold_stable: got %0d violations expected 0", tag, viol); end
    n_checks++;
    if (ack_wait == 0) begin
      // zero-wait memory: one word per two cycles, done one cycle after the last ack
      if (done_k !== 49) begin n_fail++; $display("FAIL %s_latency: done at cycle %0d expected 49", tag, done_k); end
      n_checks++;
    end
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin
      n_fail++; $display("FAIL %s_idle_after: ready %b busy %b expected 1 0", tag, desc_ready, busy);
    end
    n_checks++;
  endtask

  task automatic test_misaligned();
    int wr_seen = 0;
    logic [15:0] wd_before = words_done;
    @(negedge clk);
    desc_valid = 1'b1; desc_addr = 32'h1002; desc_len = 16'd4;
    @(negedge clk);
    desc_valid = 1'b0;
    if (err_align !== 1'b1) begin n_fail++; $display("FAIL align_err_pulse: got %b expected 1", err_align); end
    n_checks++;
    if (desc_ready !== 1'b1 || busy !== 1'b0) begin n_fail++; $display("FAIL align_stay_idle: ready %b busy %b expected 1 0", desc_ready, busy); end
    n_checks++;
    @(negedge clk);
    if (err_align !== 1'b0) begin n_fail++; $display("FAIL align_err_width: got %b expected 0", err_align); end
    n_checks++;
    repeat (4) begin
      if (mem_wr_en) wr_seen++;
      @(negedge clk);
    end
    if (wr_seen !== 0 || words_done !== wd_before) begin
      n_fail++; $display("FAIL align_no_write: %0d writes, words %0d expected 0 writes, %0d", wr_seen, words_done, wd_before);
    end
    n_checks++;
  endtask

  task automatic test_zero_len();
    bit to;
    src_q.delete();
    run_transfer(32'h4000, 16'd0, 0, 1'b0, 0, to);
    if (done_k !== 1 || done_cnt !== 1) begin
      n_fail++; $display("FAIL zero_len_done: cycle %0d count %0d expected cycle 1 count 1", done_k, done_cnt);
    end
    n_checks++;
    if (obs_addr_q.size() !== 0) begin n_fail++; $display("FAIL zero_len_writes: got %0d expected 0", obs_addr_q.size()); end
    n_checks++;
  endtask

  task automatic test_wrap();
    bit to;
    fill_src(4);
    build_expected(32'hFFFF_FFF8, 4);
    run_transfer(32'hFFFF_FFF8, 16'd4, 1, 1'b0, 0, to);
    if (obs_addr_q.size() !== 4 || to) begin n_fail++; $display("FAIL wrap_count: got %0d expected 4", obs_addr_q.size()); end
    n_checks++;
    for (int i = 0; i < 4 && i < obs_addr_q.size(); i++) begin
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL wrap_write%0d: got %h/%h expected %h/%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
      end
      n_checks++;
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int dn = 0;
    fill_src(8);
    run_transfer(32'h3000, 16'd8, 0, 1'b0, 3, to);
    rst = 1'b0;
    #1;
    if ({desc_ready, s_ready, mem_wr_en, busy, done, err_align} !== 6'b100000 ||
        {mem_addr, mem_wdata, words_done} !== 80'h0) begin
      n_fail++; $display("FAIL midreset_values: flags %b addr %h data %h words %0d expected reset values",
                         {desc_ready, s_ready, mem_wr_en, busy, done, err_align}, mem_addr, mem_wdata, words_done);
    end
    n_checks++;
    repeat (3) begin
      @(negedge clk);
      if (done || busy || mem_wr_en) dn++;
    end
    if (dn !== 0) begin n_fail++; $display("FAIL midreset_held: %0d active cycles expected 0", dn); end
    n_checks++;
    rst = 1'b1;
    fill_src(2);
    build_expected(32'h2000, 2);
    run_transfer(32'h2000, 16'd2, 0, 1'b0, 0, to);
    if (obs_addr_q.size() !== 2 || to) begin n_fail++; $display("FAIL midreset_count: got %0d expected 2", obs_addr_q.size()); end
    n_checks++;
    for (int i = 0; i < 2 && i < obs_addr_q.size(); i++) begin
      if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
        n_fail++; $display("FAIL midreset_write%0d: got %h/%h expected %h/%h", i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
      end
      n_checks++;
    end
    if (words_done !== 16'd2) begin n_fail++; $display("FAIL midreset_words: got %0d expected 2", words_done); end
    n_checks++;
  endtask

  task automatic test_random();
    bit to;
    logic [31:0] base;
    int len;
    for (int t = 0; t < 12; t++) begin
      base = $urandom & 32'hFFFF_FFFC;
      if (t % 4 == 0) base = 32'hFFFF_FFF0 | (base & 32'hC);
      len = $urandom_range(1, 7);
      fill_src(len);
      build_expected(base, len);
      run_transfer(base, 16'(len), 0, 1'b1, 0, to);
      if (to || obs_addr_q.size() !== len || done_cnt !== 1) begin
        n_fail++; $display("FAIL rand%0d_shape: writes %0d done %0d timeout %b expected %0d 1 0", t, obs_addr_q.size(), done_cnt, to, len);
      end
      n_checks++;
      for (int i = 0; i < len && i < obs_addr_q.size(); i++) begin
        if (obs_addr_q[i] !== exp_addr_q[i] || obs_data_q[i] !== exp_q[i]) begin
          n_fail++; $display("FAIL rand%0d_write%0d: got %h/%h expected %h/%h", t, i, obs_addr_q[i], obs_data_q[i], exp_addr_q[i], exp_q[i]);
        end
        n_checks++;
      end
      if (words_done !== 16'(len) || viol !== 0) begin
        n_fail++; $display("FAIL rand%0d_words: got %0d viol %0d expected %0d viol 0", t, words_done, viol, len);
      end
      n_checks++;
    end
  endtask

  initial begin
    test_reset();
    test_basic(0, "basic");
    test_basic(3, "waitstate");
    test_misaligned();
    test_zero_len();
    test_wrap();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
